tinker_mem_port: RTL

TINKER_MEM_PORT -- requirements
Module: tinker_mem_port

---
 rtl/tinker_mem_pkg.sv | 26 ++
 rtl/tinker_mem_arb.sv | 17 +
 rtl/tinker_mem_port.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types for tinker_mem_port: access sizes, port FSM states and a size-to-bytes helper.
package tinker_mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    case (sz)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/tinker_mem_arb.sv
// Fixed-priority request arbiter: the data port always wins over the fetch port when both are valid.
module tinker_mem_arb (
  input  logic idle,
  input  logic i_req_valid,
  input  logic d_req_valid,
  output logic i_req_ready,
  output logic d_req_ready,
  output logic accept,
  output logic grant_d
);

  assign grant_d     = d_req_valid;
  assign d_req_ready = idle & d_req_valid;
  assign i_req_ready = idle & i_req_valid & ~d_req_valid;
  assign accept      = d_req_ready | i_req_ready;

endmodule

// File: rtl/tinker_mem_port.sv
// Single-outstanding byte-addressed memory with a fetch port and a load/store port, fixed LATENCY.
// Optional build macro TINKER_MEM_BOUNDS_CHECK_EN: out-of-range accesses fault instead of wrapping.
module tinker_mem_port
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 524288,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [1:0]        d_req_size,
  input  logic              d_req_signed,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [63:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [63:0]       d_rsp_data,
  output logic              d_rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              lat_d, lat_we, lat_signed;
  size_e             lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       rsp_data_q;
  logic              rsp_err_q;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              idle, accept, grant_d, ent_resp;
  logic              cur_d, cur_we, cur_signed;
  size_e             cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [3:0]        nbytes;
  logic              misalign, oob, acc_err, wr_en;
  logic [IDX_W-1:0]  rd_idx [8];
  logic [63:0]       raw, ld_data;
  logic              unused_bits;

  assign idle = (state == ST_IDLE) & ~reset;

  tinker_mem_arb u_arb (
    .idle        (idle),
    .i_req_valid (i_req_valid),
    .d_req_valid (d_req_valid),
    .i_req_ready (i_req_ready),
    .d_req_ready (d_req_ready),
    .accept      (accept),
    .grant_d     (grant_d)
  );

  // In IDLE the access is described by the live inputs, afterwards by the latched copy.
  always_comb begin
    cur_d      = lat_d;
    cur_we     = lat_we;
    cur_signed = lat_signed;
    cur_size   = lat_size;
    cur_addr   = lat_addr;
    if (state == ST_IDLE) begin
      cur_d = grant_d;
      if (grant_d) begin
        cur_we     = d_req_we;
        cur_signed = d_req_signed;
        cur_size   = size_e'(d_req_size);
        cur_addr   = d_req_addr;
      end else begin
        cur_we     = 1'b0;
        cur_signed = 1'b0;
        cur_size   = SZ_W;
        cur_addr   = {i_req_addr[ADDR_W-1:2], 2'b00};
      end
    end
  end

  assign nbytes   = size_bytes(cur_size);
  assign misalign = |(cur_addr[2:0] & (nbytes[2:0] - 3'd1));

`ifdef TINKER_MEM_BOUNDS_CHECK_EN
  assign oob = ({1'b0, cur_addr} + (ADDR_W+1)'(nbytes)) > (ADDR_W+1)'(DEPTH_BYTES);
`else
  assign oob = 1'b0;
`endif

  assign acc_err = misalign | oob;
  assign wr_en   = d_req_ready & d_req_we & ~acc_err;

  always_comb begin
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      rd_idx[k]      = cur_addr[IDX_W-1:0] + IDX_W'(k);
      raw[8*k +: 8]  = mem[rd_idx[k]];
    end
  end

  always_comb begin
    ld_data = raw;
    unique case (cur_size)
      SZ_B:    ld_data = {{56{cur_signed & raw[7]}},  raw[7:0]};
      SZ_H:    ld_data = {{48{cur_signed & raw[15]}}, raw[15:0]};
      SZ_W:    ld_data = {{32{cur_signed & raw[31]}}, raw[31:0]};
      default: ld_data = raw;
    endcase
  end

  always_comb begin
    state_nx = state;
    ent_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = ST_RESP;
            ent_resp = 1'b1;
          end else begin
            state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nx = ST_RESP;
          ent_resp = 1'b1;
        end
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_d      <= 1'b0;
      lat_we     <= 1'b0;
      lat_signed <= 1'b0;
      lat_size   <= SZ_B;
      lat_addr   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == ST_IDLE) && accept) begin
        cnt        <= CNT_LOAD;
        lat_d      <= cur_d;
        lat_we     <= cur_we;
        lat_signed <= cur_signed;
        lat_size   <= cur_size;
        lat_addr   <= cur_addr;
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (ent_resp) begin
        rsp_data_q <= (cur_we | acc_err) ? 64'd0 : ld_data;
        rsp_err_q  <= cur_d & acc_err;
      end
    end
  end

  // Storage has no reset so contents survive a reset; stores commit on the accept edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nbytes) mem[rd_idx[k]] <= d_req_wdata[8*k +: 8];
      end
    end
  end

  assign i_rsp_valid = (state == ST_RESP) & ~lat_d;
  assign d_rsp_valid = (state == ST_RESP) & lat_d;
  assign i_rsp_data  = i_rsp_valid ? rsp_data_q[31:0] : 32'd0;
  assign d_rsp_data  = d_rsp_valid ? rsp_data_q : 64'd0;
  assign d_rsp_err   = d_rsp_valid & rsp_err_q;

  assign unused_bits = ^{cur_addr, i_req_addr[1:0], rsp_data_q[63:32] & 32'd0};

endmodule
